// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
//   uart_state_e : receiver frame-tracking states
//   DATA_BITS    : payload bits per frame
//   baud_div()   : clk cycles per oversample tick, rounded to nearest
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running tick generator: one-clk pulse every DIV clks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clear : restart the period; the first tick follows DIV clks later
//   tick  : single-cycle pulse
// DIV=1 gives a tick on every clk (uart_tx with OVERSAMPLE=1 at clk==baud).
module uart_baud_tick #(
  parameter int unsigned DIV = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = !clear && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampling, majority voting and a valid/ready output.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx         : serial line, asynchronous to clk, idle high
//   data       : received byte, stable while valid && !ready
//   valid      : data holds an unconsumed byte
//   ready      : consumer accepts data when valid && ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, byte completed while previous byte unconsumed
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 48000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);

  // Sample index s = 0 is the start edge itself; the tick that advances s to
  // k is the sample at s = k. Voting uses s = H-1, H, H+1.
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_M0     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_M1     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 rx_meta_q;
  logic                 rx_s;
  logic                 clear;
  logic                 tick;
  logic [SW-1:0]        s_q;
  logic [SW-1:0]        s_next;
  logic                 m0_q;
  logic                 m1_q;
  logic                 maj;
  logic                 decide;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  uart_state_e          state_q;
  uart_state_e          state_d;
  logic                 deliver;
  logic                 stop_bad;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  // Two-flop synchronizer; idles high so reset does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // Restart tick phase and sample index on the start edge.
  assign clear = (state_q == IDLE) && !rx_s;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  assign s_next = (s_q == S_LAST) ? '0 : s_q + 1'b1;
  assign decide = tick && (s_next == S_DEC);
  assign maj    = (m0_q & m1_q) | (m0_q & rx_s) | (m1_q & rx_s);

  always_comb begin
    state_d  = state_q;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (decide) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (decide && (bit_cnt_q == BIT_LAST)) state_d = STOP;
      end
      STOP: begin
        if (decide) begin
          if (maj) begin
            // Re-arm mid stop bit so a back-to-back start edge is not missed.
            state_d = IDLE;
            deliver = 1'b1;
          end else begin
            state_d  = WAIT_HIGH;
            stop_bad = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low break must not restart framing until the line recovers.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      m0_q      <= 1'b0;
      m1_q      <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        s_q <= '0;
      end else if (tick) begin
        s_q <= s_next;
      end
      if (tick && (s_next == S_M0)) m0_q <= rx_s;
      if (tick && (s_next == S_M1)) m1_q <= rx_s;
      if (state_q == START) begin
        bit_cnt_q <= '0;
      end else if ((state_q == DATA) && decide) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        shreg_q   <= {maj, shreg_q[DATA_BITS-1:1]};
      end
    end
  end

  // Output stage: a new byte replaces the held one only if it is being
  // consumed in the same cycle; otherwise the new byte is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= deliver && valid_q && !ready;
      if (deliver && (!valid_q || ready)) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: main instance at 1.6 MHz / 10 kbaud / x16 (DIV=10,
// 160 clks per bit), plus a default-parameter instance for the DIV=26 case.
module tb_uart_rx;

  // Start edge to valid: 2 sync clks + 1 edge detect + 153 ticks of DIV clks
  // (stop-bit vote at s=H+1 of bit 9: 9*16 + 9 ticks), output registered on
  // the deciding edge.
  localparam int BIT_CLKS = 160;
  localparam int LAT      = (9 * 16 + 8 + 1) * 10 + 3;  // 1533
  localparam int DEF_BIT  = 26 * 16;                     // 416
  localparam int DEF_LAT  = (9 * 16 + 8 + 1) * 26 + 3;  // 3981

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  logic       rx_def;
  logic       ready_def;
  logic [7:0] data_def;
  logic       valid_def;
  logic       frame_err_def;
  logic       overrun_def;

  uart_rx #(
    .CLK_HZ     (1600000),
    .BAUD       (10000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  uart_rx dut_def (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_def),
    .data      (data_def),
    .valid     (valid_def),
    .ready     (ready_def),
    .frame_err (frame_err_def),
    .overrun   (overrun_def)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcnt  = 0;
  int fcnt  = 0;
  int ocnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each scheduled frame resolves LAT clks after its start edge into
  // either a byte offered to the consumer or a framing error.
  typedef struct {
    int         at;
    bit         ok;
    logic [7:0] dat;
  } ev_t;

  ev_t        evq[$];
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_ferr  = 1'b0;
  logic       exp_ovr   = 1'b0;

  initial begin
    ev_t ev;
    bit  took;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        evq.delete();
      end else begin
        cyc++;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        took     = 1'b0;
        if (evq.size() > 0 && evq[0].at == cyc) begin
          ev = evq.pop_front();
          if (!ev.ok) begin
            exp_ferr = 1'b1;
          end else if (!exp_valid || ready) begin
            exp_data  = ev.dat;
            exp_valid = 1'b1;
            took      = 1'b1;
          end else begin
            exp_ovr = 1'b1;
          end
        end
        if (!took && exp_valid && ready) exp_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, mid clock-high phase.
  initial begin
    @(posedge rst_n);
    forever begin
      @(posedge clk);
      #3;
      chk("valid", {31'd0, valid}, {31'd0, exp_valid});
      chk("data", {24'd0, data}, {24'd0, exp_data});
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
      chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      if (valid) vcnt++;
      if (frame_err) fcnt++;
      if (overrun) ocnt++;
    end
  end

  // Called on a negedge; leaves the stop level on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit sched);
    if (sched) evq.push_back('{at: cyc + LAT, ok: stop, dat: b});
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int n_main;
  int n_def;
  int k;
  int v0;
  int f0;
  int o0;

  initial begin
    rst_n     = 1'b0;
    rx        = 1'b1;
    ready     = 1'b1;
    rx_def    = 1'b1;
    ready_def = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Default parameters: DIV=26, 0xA5.
    fork
      begin
        rx_def = 1'b0;
        repeat (DEF_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx_def = (8'hA5 >> i) & 8'h01;
          repeat (DEF_BIT) @(negedge clk);
        end
        rx_def = 1'b1;
        repeat (DEF_BIT) @(negedge clk);
      end
      begin
        n_def = 0;
        while (n_def < 5000) begin
          @(posedge clk);
          #3;
          n_def++;
          if (valid_def) break;
        end
        chk("def_latency", n_def, DEF_LAT);
        chk("def_data", {24'd0, data_def}, 32'h0000_00A5);
        @(posedge clk);
        #3;
        chk("def_valid_one_cycle", {31'd0, valid_def}, 32'd0);
      end
    join
    repeat (20) @(negedge clk);

    // Main instance: 0xA5 with ready=1, exact latency and one-cycle valid.
    v0 = vcnt;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        n_main = 0;
        while (n_main < 3000) begin
          @(posedge clk);
          #3;
          n_main++;
          if (valid) break;
        end
        chk("a5_latency", n_main, LAT);
        chk("a5_data", {24'd0, data}, 32'h0000_00A5);
      end
    join
    repeat (20) @(negedge clk);
    chk("a5_valid_cycles", vcnt - v0, 1);

    // Short low glitch: nothing reported, then 0x5A.
    v0 = vcnt;
    f0 = fcnt;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_valid", vcnt - v0, 0);
    chk("glitch_no_ferr", fcnt - f0, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("5a_data", {24'd0, data}, 32'h0000_005A);

    // Bad stop bit, then a long break: exactly one frame_err.
    v0 = vcnt;
    f0 = fcnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("3c_ferr_pulses", fcnt - f0, 1);
    chk("3c_no_valid", vcnt - v0, 0);
    repeat (2000) @(negedge clk);
    chk("break_ferr_pulses", fcnt - f0, 1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("55_data", {24'd0, data}, 32'h0000_0055);

    // Overrun: 0x11 held, 0x22 dropped.
    ready = 1'b0;
    o0 = ocnt;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("ovr_data_held", {24'd0, data}, 32'h0000_0011);
    chk("ovr_valid_held", {31'd0, valid}, 32'd1);
    chk("ovr_pulses", ocnt - o0, 1);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_drained", {31'd0, valid}, 32'd0);
    ready = 1'b0;
    repeat (20) @(negedge clk);

    // Ready asserted exactly on the 0x22 delivery cycle: replace, no overrun.
    o0 = ocnt;
    send_frame(8'h11, 1'b1, 1'b1);
    k = cyc;
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        while (cyc < k + LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("swap_data", {24'd0, data}, 32'h0000_0022);
    chk("swap_valid", {31'd0, valid}, 32'd1);
    chk("swap_no_ovr", ocnt - o0, 0);

    // Reset during bit 4 of 0xFF while a byte is still pending.
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_data", {24'd0, data}, 32'd0);
    chk("arst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    f0 = fcnt;
    o0 = ocnt;
    repeat (200) @(negedge clk);
    ready = 1'b1;
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("81_data", {24'd0, data}, 32'h0000_0081);
    chk("81_no_ferr", fcnt - f0, 0);
    chk("81_no_ovr", ocnt - o0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
